// File: rtl/disp_pkg.sv
// Shared display constants for the digit scan path and its segment decoders.
package disp_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam logic        AN_OFF       = 1'b1;
  localparam int unsigned DEF_N_DIGITS = 4;
  localparam int unsigned DEF_SCAN_DIV = 50000;
  localparam int unsigned DEF_DIV_W    = 16;

endpackage

// File: rtl/digit_scan_mux_prescaler.sv
// Slot-rate prescaler: counts 0..SCAN_DIV-1 and flags the last count as a tick.
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  logic [DIV_W-1:0] r_count;

  assign o_tick = (r_count == DIV_W'(SCAN_DIV - 1));

  // Free-running wrap counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexes N_DIGITS 4-bit codes onto a shared code bus with active-low
// digit enables, double-buffered loads and optional leading-zero blanking.
module digit_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS = DEF_N_DIGITS,
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
  parameter int unsigned DIV_W    = DEF_DIV_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [DIGIT_W*N_DIGITS-1:0]  digits_in,
  input  logic                         blank_lz,
  output logic [DIGIT_W-1:0]           digit_code,
  output logic [N_DIGITS-1:0]          an_n,
  output logic                         frame_done,
  output logic                         pending
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned BUS_W = DIGIT_W * N_DIGITS;

  logic                 w_tick;
  logic                 w_boundary;
  logic                 r_run;
  logic                 r_tick_d;
  logic [IDX_W-1:0]     r_idx;
  logic [BUS_W-1:0]     r_shadow;
  logic [BUS_W-1:0]     r_active;
  logic [N_DIGITS-1:0]  w_blank;
  logic [N_DIGITS-1:0]  w_sel_n;
  logic [DIGIT_W-1:0]   w_cur;
  logic                 w_zero_above;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (w_tick)
  );

  assign w_boundary = w_tick && r_run && (r_idx == IDX_W'(N_DIGITS - 1));
  assign frame_done = w_boundary;
  assign w_cur      = r_active[DIGIT_W*r_idx +: DIGIT_W];
  assign w_sel_n    = ~(N_DIGITS'(1) << r_idx);

  // Slot index; the very first tick after reset opens slot 0 instead of advancing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_run    <= 1'b0;
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= w_tick;
      if (w_tick) begin
        if (!r_run) begin
          r_run <= 1'b1;
        end else if (r_idx == IDX_W'(N_DIGITS - 1)) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // Double buffer: a load on the boundary cycle bypasses the shadow so no stale frame is shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      pending  <= 1'b0;
    end else if (w_boundary) begin
      if (load) begin
        r_active <= digits_in;
        r_shadow <= digits_in;
      end else if (pending) begin
        r_active <= r_shadow;
      end
      pending <= 1'b0;
    end else if (load) begin
      r_shadow <= digits_in;
      pending  <= 1'b1;
    end
  end

  // Leading-zero mask: digit k blanks when it and every digit above it are zero; digit 0 never
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above && (r_active[DIGIT_W*i +: DIGIT_W] == '0);
      w_blank[i]   = w_zero_above;
    end
  end

  // Output registers: dead time on tick, then enable the selected digit one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_code <= '0;
      an_n       <= {N_DIGITS{AN_OFF}};
    end else if (w_tick) begin
      an_n <= {N_DIGITS{AN_OFF}};
    end else if (r_tick_d) begin
      digit_code <= w_cur;
      an_n       <= (blank_lz && w_blank[r_idx]) ? {N_DIGITS{AN_OFF}} : w_sel_n;
    end
  end

endmodule
